// File: rtl/shake_absorb_ctrl.sv
// SHAKE absorb sequencer: feeds message words into the rate SIPO, inserts SHAKE padding
// and zero capacity fill, and hands each full DEPTH-word block to the permutation.
module shake_absorb_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [3:0]       in_bytes,
    output logic             in_ready,
    output logic             sipo_en,
    output logic [WIDTH-1:0] sipo_data,
    output logic             block_valid,
    output logic             block_last,
    input  logic             block_ready,
    output logic             busy
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam logic [CNT_W-1:0] RATE128 = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] RATE256 = CNT_W'(17);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [WIDTH-1:0] PAD_START = WIDTH'(8'h1F);
    localparam logic [WIDTH-1:0] PAD_END   = {8'h80, {(WIDTH - 8){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PAD,
        S_FILL,
        S_HANDOFF
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             pad_pending_q, pad_pending_d;
    logic             last_q, last_d;

    logic [CNT_W-1:0] wcnt_inc;
    logic             last_pos;
    logic             rate_full;
    state_e           after_rate;
    logic [WIDTH-1:0] pad_word;

    assign wcnt_inc   = wcnt_q + CNT_W'(1);
    assign last_pos   = (wcnt_q == rate_q - CNT_W'(1));
    assign rate_full  = (wcnt_inc == rate_q);
    // SHAKE128 rate covers the whole SIPO, so there is no capacity region to fill
    assign after_rate = (rate_q == DEPTH_C) ? S_HANDOFF : S_FILL;
    assign busy       = (state_q != S_IDLE);

    // Truncate the final partial word and append the 0x1F domain/pad byte
    always_comb begin
        pad_word = '0;
        for (int k = 0; k < int'(NBYTES); k++) begin
            if (k < int'(in_bytes)) begin
                pad_word[8*k +: 8] = in_data[8*k +: 8];
            end else if (k == int'(in_bytes)) begin
                pad_word[8*k +: 8] = 8'h1F;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wcnt_q        <= '0;
            rate_q        <= '0;
            pad_pending_q <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            rate_q        <= rate_d;
            pad_pending_q <= pad_pending_d;
            last_q        <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        rate_d        = rate_q;
        pad_pending_d = pad_pending_q;
        last_d        = last_q;
        in_ready      = 1'b0;
        sipo_en       = 1'b0;
        sipo_data     = '0;
        block_valid   = 1'b0;
        block_last    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rate_d        = mode ? RATE256 : RATE128;
                    wcnt_d        = '0;
                    pad_pending_d = 1'b0;
                    last_d        = 1'b0;
                    state_d       = S_ABSORB;
                end
            end
            S_ABSORB: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sipo_en = 1'b1;
                    wcnt_d  = wcnt_inc;
                    if (in_last && (in_bytes < 4'd8)) begin
                        sipo_data = pad_word | (last_pos ? PAD_END : '0);
                        last_d    = 1'b1;
                        state_d   = rate_full ? after_rate : S_PAD;
                    end else begin
                        // A full final word defers the 0x1F byte to a generated word
                        sipo_data     = in_data;
                        pad_pending_d = pad_pending_q | in_last;
                        if (rate_full) begin
                            state_d = after_rate;
                        end else if (in_last) begin
                            state_d = S_PAD;
                        end
                    end
                end
            end
            S_PAD: begin
                sipo_en       = 1'b1;
                sipo_data     = (pad_pending_q ? PAD_START : '0) | (last_pos ? PAD_END : '0);
                pad_pending_d = 1'b0;
                last_d        = 1'b1;
                wcnt_d        = wcnt_inc;
                if (rate_full) begin
                    state_d = after_rate;
                end
            end
            S_FILL: begin
                sipo_en = 1'b1;
                wcnt_d  = wcnt_inc;
                if (wcnt_inc == DEPTH_C) begin
                    state_d = S_HANDOFF;
                end
            end
            S_HANDOFF: begin
                block_valid = 1'b1;
                block_last  = last_q;
                if (block_ready) begin
                    wcnt_d = '0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (pad_pending_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_ABSORB;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shake_absorb_ctrl.sv
// Directed bench for shake_absorb_ctrl: rebuilds each handed-off block from the SIPO
// shift stream and compares it with hand-computed SHAKE padded blocks.
module tb_shake_absorb_ctrl;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 21;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [3:0]       in_bytes;
    logic             in_ready;
    logic             sipo_en;
    logic [WIDTH-1:0] sipo_data;
    logic             block_valid;
    logic             block_last;
    logic             block_ready;
    logic             busy;

    shake_absorb_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .in_ready   (in_ready),
        .sipo_en    (sipo_en),
        .sipo_data  (sipo_data),
        .block_valid(block_valid),
        .block_last (block_last),
        .block_ready(block_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0    = 0;
    int t_idle = 0;

    always @(posedge clk) cyc++;

    // Block recorder: collects shifted words and snapshots them on each accepted handoff
    logic [WIDTH-1:0] cur [DEPTH];
    logic [WIDTH-1:0] bw  [2][DEPTH];
    bit               bl  [2];
    int               bsh [2];
    int               widx = 0;
    int               nblk = 0;
    int               viol = 0;
    bit               rec_clr = 1'b0;

    always @(negedge clk) begin
        if (rec_clr) begin
            widx = 0;
            nblk = 0;
        end else begin
            if (sipo_en) begin
                if (widx < int'(DEPTH)) cur[widx] = sipo_data;
                widx++;
                if (block_valid) viol++;
            end
            if (block_valid && block_ready) begin
                if (nblk < 2) begin
                    for (int i = 0; i < int'(DEPTH); i++) bw[nblk][i] = cur[i];
                    bl[nblk]  = block_last;
                    bsh[nblk] = widx;
                end
                nblk++;
                widx = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_msg(input logic m);
        rec_clr = 1'b1;
        tick();
        rec_clr = 1'b0;
        start = 1'b1;
        mode  = m;
        t0    = cyc;
        tick();
        start = 1'b0;
        mode  = ~m;
    endtask

    task automatic send(input logic [63:0] d, input logic l, input logic [3:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check(tag, 64'(busy), 64'd0);
        t_idle = cyc;
        tick();
    endtask

    function automatic logic [63:0] or_range(input int blk, input int lo, input int hi);
        logic [63:0] acc = '0;
        for (int i = lo; i <= hi; i++) acc |= bw[blk][i];
        return acc;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; in_bytes = '0; block_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_block_valid", 64'(block_valid), 64'd0);
        check("rst_sipo_en", 64'(sipo_en), 64'd0);
        check("rst_sipo_data", sipo_data, 64'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // SHAKE128 empty message
        begin_msg(1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        wait_idle("t1_idle_timeout");
        check("t1_latency", 64'(t_idle - t0), 64'd23);
        check("t1_nblk", 64'(nblk), 64'd1);
        check("t1_w0", bw[0][0], 64'h0000_0000_0000_001F);
        check("t1_w1_19", or_range(0, 1, 19), 64'd0);
        check("t1_w20", bw[0][20], 64'h8000_0000_0000_0000);
        check("t1_last", 64'(bl[0]), 64'd1);
        check("t1_shifts", 64'(bsh[0]), 64'd21);

        // SHAKE256, 3 bytes with junk above the valid bytes
        begin_msg(1'b1);
        send(64'hDEAD_BEEF_11CC_BBAA, 1'b1, 4'd3);
        wait_idle("t2_idle_timeout");
        check("t2_nblk", 64'(nblk), 64'd1);
        check("t2_w0", bw[0][0], 64'h0000_0000_1FCC_BBAA);
        check("t2_w1_15", or_range(0, 1, 15), 64'd0);
        check("t2_w16", bw[0][16], 64'h8000_0000_0000_0000);
        check("t2_fill", or_range(0, 17, 20), 64'd0);
        check("t2_shifts", 64'(bsh[0]), 64'd21);
        check("t2_last", 64'(bl[0]), 64'd1);

        // SHAKE256, 17 full words, last one full
        begin_msg(1'b1);
        for (int i = 0; i < 17; i++)
            send(64'h1111_0000_0000_0000 + 64'(i), (i == 16), (i == 16) ? 4'd8 : 4'd3);
        wait_idle("t3_idle_timeout");
        check("t3_nblk", 64'(nblk), 64'd2);
        check("t3_b0_w0", bw[0][0], 64'h1111_0000_0000_0000);
        check("t3_b0_w16", bw[0][16], 64'h1111_0000_0000_0010);
        check("t3_b0_fill", or_range(0, 17, 20), 64'd0);
        check("t3_b0_last", 64'(bl[0]), 64'd0);
        check("t3_b1_w0", bw[1][0], 64'h0000_0000_0000_001F);
        check("t3_b1_w1_15", or_range(1, 1, 15), 64'd0);
        check("t3_b1_w16", bw[1][16], 64'h8000_0000_0000_0000);
        check("t3_b1_fill", or_range(1, 17, 20), 64'd0);
        check("t3_b1_last", 64'(bl[1]), 64'd1);
        check("t3_b1_shifts", 64'(bsh[1]), 64'd21);

        // SHAKE128, 21st word last with 7 bytes: pad bytes merge into 0x9F
        begin_msg(1'b0);
        for (int i = 0; i < 21; i++)
            send((i == 20) ? 64'hFFEE_DDCC_BBAA_9988 : 64'h2222_0000_0000_0000 + 64'(i),
                 (i == 20), 4'd7);
        wait_idle("t4_idle_timeout");
        check("t4_nblk", 64'(nblk), 64'd1);
        check("t4_w0", bw[0][0], 64'h2222_0000_0000_0000);
        check("t4_w20", bw[0][20], 64'h9FEE_DDCC_BBAA_9988);
        check("t4_last", 64'(bl[0]), 64'd1);

        // Handoff stall: block_ready low for 10 cycles
        block_ready = 1'b0;
        begin_msg(1'b0);
        for (int i = 0; i < 21; i++) send(64'hC0DE_0000_0000_0000 + 64'(i), 1'b0, 4'd0);
        in_valid = 1'b1;
        in_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_stall_valid", 64'(block_valid), 64'd1);
        end
        check("t5_stall_in_ready", 64'(in_ready), 64'd0);
        check("t5_stall_sipo_en", 64'(sipo_en), 64'd0);
        check("t5_stall_last", 64'(block_last), 64'd0);
        tick();
        in_valid    = 1'b0;
        block_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t5_absorb_in_ready", 64'(in_ready), 64'd1);
        check("t5_absorb_valid", 64'(block_valid), 64'd0);
        tick();
        send(64'h0, 1'b1, 4'd0);
        wait_idle("t5_idle_timeout");
        check("t5_nblk", 64'(nblk), 64'd2);
        check("t5_b0_w0", bw[0][0], 64'hC0DE_0000_0000_0000);
        check("t5_b0_w20", bw[0][20], 64'hC0DE_0000_0000_0014);
        check("t5_b0_last", 64'(bl[0]), 64'd0);
        check("t5_b1_w0", bw[1][0], 64'h0000_0000_0000_001F);
        check("t5_b1_w20", bw[1][20], 64'h8000_0000_0000_0000);
        check("t5_b1_last", 64'(bl[1]), 64'd1);
        check("t5_no_shift_in_handoff", 64'(viol), 64'd0);

        // Reset mid-message, then a clean SHAKE128 message
        begin_msg(1'b1);
        for (int i = 0; i < 5; i++) send(64'h3333_0000_0000_0000 + 64'(i), 1'b0, 4'd0);
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_in_ready", 64'(in_ready), 64'd0);
        check("t6_rst_sipo_en", 64'(sipo_en), 64'd0);
        check("t6_rst_block_valid", 64'(block_valid), 64'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        begin_msg(1'b0);
        send(64'h0123_4567_89AB_CDEF, 1'b0, 4'd0);
        send(64'h5555_5555_5555_3344, 1'b1, 4'd2);
        wait_idle("t6_idle_timeout");
        check("t6_nblk", 64'(nblk), 64'd1);
        check("t6_w0", bw[0][0], 64'h0123_4567_89AB_CDEF);
        check("t6_w1", bw[0][1], 64'h0000_0000_001F_3344);
        check("t6_w2_19", or_range(0, 2, 19), 64'd0);
        check("t6_w20", bw[0][20], 64'h8000_0000_0000_0000);
        check("t6_shifts", 64'(bsh[0]), 64'd21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shake_absorb_ctrl.md
# shake_absorb_ctrl

Sequences the SHAKE absorb path. It accepts a stream of message words, drives the shift enable and data of the serial-to-parallel rate buffer (`WIDTH` bits in, `DEPTH` words out), and inserts SHAKE padding and zero capacity fill. It presents each completed block to the Keccak permutation with a valid/ready handshake. It sits between the message input FIFO and the SIPO buffer / permutation core.

## Interface
- `WIDTH`, 64, word width in bits; must be 64.
- `DEPTH`, 21, SIPO depth in words; equals the SHAKE128 rate.
- `clk` input 1 — clock.
- `rst` input 1 — asynchronous, active-high reset.
- `start` input 1 — one-cycle pulse in IDLE; begins a message. Ignored outside IDLE.
- `mode` input 1 — sampled on `start`: 0 = SHAKE128 (R=21 words), 1 = SHAKE256 (R=17 words).
- `in_valid` input 1 — message word valid.
- `in_data` input WIDTH — message word; byte k is at bits [8k+7:8k].
- `in_last` input 1 — final message word.
- `in_bytes` input 4 — valid bytes in the last word, 0..8. Ignored when `in_last`=0.
- `in_ready` output 1 — controller accepts a word.
- `sipo_en` output 1 — SIPO shift enable.
- `sipo_data` output WIDTH — SIPO data_in.
- `block_valid` output 1 — SIPO holds a complete DEPTH-word block.
- `block_last` output 1 — the block is the final one of the message; valid with `block_valid`.
- `block_ready` input 1 — permutation takes the block.
- `busy` output 1 — state ≠ IDLE.

## Operation
- State machine states: IDLE, ABSORB, PAD, FILL, HANDOFF.
- Registers: `wcnt` (0..DEPTH-1), `rate_q`, `pad_pending`, `last_q`.
- **IDLE.** On `start`: `rate_q` ← R(mode), `wcnt` ← 0, go to ABSORB.
- **ABSORB.** `in_ready`=1. On a handshake, `sipo_en`=1 and `wcnt`++.
  - Non-last word: `sipo_data`=`in_data`.
  - Last word, `in_bytes`=b<8: bytes ≥b are zeroed, byte b is OR'd with 0x1F, and the word is marked padded.
  - Last word, b=8: the word passes unchanged and `pad_pending` is set.
  - On the padded word, byte 7 of word position `rate_q`-1 is additionally OR'd with 0x80. If b=7 at that position, byte 7 = 0x9F.
  - Next state after a word:
    - `wcnt` reaches `rate_q` and the message is not finished → FILL.
    - Padding is done → PAD (pad words remaining) or FILL.
    - `pad_pending` → PAD.
- **PAD.** Shifts generated words until `wcnt`=`rate_q`.
  - First word when `pad_pending`: 0x1F at byte 0.
  - Remaining words: zero.
  - Position `rate_q`-1 gets 0x80 in byte 7 (0x9F if it is also the 0x1F word).
  - If `pad_pending` is still set when `wcnt`=`rate_q` (full last word landed at position R-1), the block is handed off with `block_last`=0. A new block then starts in PAD.
- **FILL.** Shifts zero words while `wcnt` < DEPTH (the capacity region). For SHAKE128 it is skipped.
- **HANDOFF.** `block_valid`=1 and `block_last`=`last_q`. On `block_ready`, `wcnt` ← 0.
  - If `last_q`=1 → IDLE.
  - Else if `pad_pending` → PAD.
  - Else → ABSORB.
- Every block is exactly DEPTH shifts, so SIPO content is fully overwritten. The SIPO has no reset, and none is needed.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- `rst` mid-message aborts immediately. The partial block is never presented.
- `in_ready`, `sipo_en`, `sipo_data`, `block_valid` and `block_last` are combinational from state and registers. `sipo_data` is also combinational from `in_data`.
- Throughput:
  - One word per cycle in ABSORB (zero-bubble when `in_valid` is held).
  - One generated word per cycle in PAD and FILL.
  - HANDOFF → ABSORB costs one cycle.
- `in_ready`=0 during PAD, FILL and HANDOFF. `in_valid` with `in_ready`=0 has no effect.
- `block_valid` holds until `block_ready`. No SIPO shift occurs while `block_valid`=1.
- `start` during `busy` is ignored. `mode` changes mid-message are ignored.

## Test plan
- **SHAKE128, empty message** (`start`; one word, `in_last`=1, `in_bytes`=0) → word0 = 0x1F, words 1..19 = 0, word20 = 0x8000_0000_0000_0000. One block with `block_last`=1, `busy` low 23 cycles after `start`.
- **SHAKE256, 3 bytes** 0x00_0000_0000_CCBBAA, b=3 → word0 = 0x1FCCBBAA, words 1..15 = 0, word16 = 0x80<<56, words 17..20 = 0 (FILL). 21 shifts total.
- **SHAKE256, 17 full words, last with b=8** → first block `block_last`=0. Second block: word0 = 0x1F, word16 = 0x80<<56, `block_last`=1.
- **SHAKE128, 21st word last with b=7** → byte 7 of word 20 = 0x9F, single block.
- **`block_ready` held low 10 cycles** → `block_valid` stays high, `in_ready`=0, no `sipo_en`. Then `block_ready` → ABSORB next cycle.
- **`rst` asserted at word 5 of a message** → outputs 0 asynchronously. A following `start` yields a correct single-block result.
